rat_ckpt: RTL and testbench

N-way register alias table with architectural RRAT, an internal free list, and branch checkpoints for single-cycle mispredict recovery. Renames up to WAYS instructions per cycle, with intra-group dependency bypass. Commits up to WAYS retirements per cycle and returns overwritten physical registers to the free list. Sits between decode/dispatch and RS/ROB; successor to the 2-way rat, which recovers only by full flush.

---
 rtl/rat_pkg.sv | 42 ++++
 rtl/rat_freelist.sv | 48 ++++
 rtl/rat_ckpt.sv | 180 ++++++++++++++++++
 tb/tb_rat_ckpt.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared widths, map/free-list types and small helpers for the checkpointed rename table.
package rat_pkg;
    localparam int WAYS      = 2;
    localparam int ARCH_REGS = 32;
    localparam int ARCH_IDX  = 5;
    localparam int PRF_SZ    = 64;
    localparam int PRF_IDX   = 6;
    localparam int CKPTS     = 4;
    localparam int CKPT_IDX  = 2;

    localparam logic [ARCH_IDX-1:0] ZERO_REG = 5'd31;

    typedef logic [PRF_IDX-1:0]         preg_t;
    typedef preg_t [ARCH_REGS-1:0]      map_t;
    typedef logic [PRF_SZ-1:0]          fl_t;

    function automatic preg_t lowest_free(input fl_t fl);
        preg_t idx;
        idx = '0;
        for (int i = PRF_SZ - 1; i >= 0; i--) begin
            if (fl[i]) idx = preg_t'(i);
        end
        return idx;
    endfunction

    function automatic logic [PRF_IDX:0] count_ones(input fl_t fl);
        logic [PRF_IDX:0] n;
        n = '0;
        for (int i = 0; i < PRF_SZ; i++) begin
            n = n + {{PRF_IDX{1'b0}}, fl[i]};
        end
        return n;
    endfunction

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) begin
            m[i] = preg_t'(i);
        end
        return m;
    endfunction
endpackage

// File: rtl/rat_freelist.sv
// Physical register free list: per-way lowest-index allocation chain, retire OR-in, bulk reload.
module rat_freelist
    import rat_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [WAYS-1:0]     alloc_need,
    input  logic                alloc_en,
    input  fl_t                 free_mask,
    input  logic                load_en,
    input  fl_t                 load_val,
    output preg_t [WAYS-1:0]    alloc_idx,
    output fl_t   [WAYS:0]      avail,
    output fl_t                 free_vec,
    output logic [PRF_IDX:0]    free_cnt
);

    fl_t free_reg;
    fl_t chain_cur;

    // avail[k] is the list seen by way k; each way needing a preg removes its pick
    // so younger ways always see the remaining lowest entry.
    always_comb begin
        chain_cur = free_reg;
        avail[0]  = free_reg;
        for (int k = 0; k < WAYS; k++) begin
            alloc_idx[k] = lowest_free(chain_cur);
            if (alloc_need[k]) chain_cur[alloc_idx[k]] = 1'b0;
            avail[k+1] = chain_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_reg <= {{(PRF_SZ-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
        end else if (load_en) begin
            free_reg <= load_val | free_mask;
        end else if (alloc_en) begin
            free_reg <= avail[WAYS] | free_mask;
        end else begin
            free_reg <= free_reg | free_mask;
        end
    end

    assign free_vec = free_reg;
    assign free_cnt = count_ones(free_reg);

endmodule

// File: rtl/rat_ckpt.sv
// Multi-way register alias table with RRAT, free list and branch checkpoints for one-cycle recovery.
module rat_ckpt
    import rat_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WAYS-1:0]              issue,
    input  logic [WAYS*ARCH_IDX-1:0]     rega_idx_in,
    input  logic [WAYS*ARCH_IDX-1:0]     regb_idx_in,
    input  logic [WAYS*ARCH_IDX-1:0]     dest_idx_in,
    input  logic [WAYS-1:0]              ckpt_req,
    output logic [WAYS*PRF_IDX-1:0]      prega_idx_out,
    output logic [WAYS*PRF_IDX-1:0]      pregb_idx_out,
    output logic [WAYS*PRF_IDX-1:0]      pdest_idx_out,
    output logic [WAYS*CKPT_IDX-1:0]     ckpt_id_out,
    output logic                         stall_out,
    output logic [PRF_IDX:0]             free_cnt_out,
    input  logic [WAYS-1:0]              retire,
    input  logic [WAYS*ARCH_IDX-1:0]     retire_dest_idx_in,
    input  logic [WAYS*PRF_IDX-1:0]      retire_pdest_idx_in,
    input  logic                         recover,
    input  logic [CKPT_IDX-1:0]          recover_id,
    input  logic                         release_en,
    input  logic [CKPT_IDX-1:0]          release_id,
    input  logic                         flush
);

    localparam logic [PRF_IDX:0] WAYS_CNT = (PRF_IDX+1)'(WAYS);

    logic [WAYS-1:0][ARCH_IDX-1:0] src_a, src_b, dst, rdst;
    preg_t [WAYS-1:0]              rpd, prega, pregb, pdest, alloc_idx;

    assign src_a = rega_idx_in;
    assign src_b = regb_idx_in;
    assign dst   = dest_idx_in;
    assign rdst  = retire_dest_idx_in;
    assign rpd   = retire_pdest_idx_in;

    map_t                rat_reg, rrat_reg, rrat_next, group_map, snap_rat;
    map_t                ckpt_rat_reg [CKPTS];
    fl_t                 ckpt_fl_reg  [CKPTS];
    logic [CKPTS-1:0]    ckpt_valid_reg, ckpt_valid_next, squash_mask;
    logic [CKPT_IDX-1:0] tail_reg, squash_span;

    fl_t                 retire_free, rrat_used, flush_fl, snap_fl, free_vec;
    fl_t [WAYS:0]        avail;
    logic [PRF_IDX:0]    free_cnt;
    logic [WAYS-1:0]     alloc_need;
    logic                any_ckpt, stall, accept;

    assign any_ckpt = |(issue & ckpt_req);
    assign stall    = (free_cnt < WAYS_CNT) || (any_ckpt && ckpt_valid_reg[tail_reg]);
    assign accept   = !flush && !recover && !stall;

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            alloc_need[k] = issue[k] && (dst[k] != ZERO_REG);
        end
    end

    rat_freelist u_freelist (
        .clk        (clk),
        .reset      (reset),
        .alloc_need (alloc_need),
        .alloc_en   (accept),
        .free_mask  (retire_free),
        .load_en    (flush || recover),
        .load_val   (flush ? flush_fl : ckpt_fl_reg[recover_id]),
        .alloc_idx  (alloc_idx),
        .avail      (avail),
        .free_vec   (free_vec),
        .free_cnt   (free_cnt)
    );

    // Walking the group in way order gives intra-group bypass and youngest-writer-wins for free.
    always_comb begin
        group_map = rat_reg;
        snap_rat  = rat_reg;
        snap_fl   = avail[0];
        for (int k = 0; k < WAYS; k++) begin
            prega[k] = group_map[src_a[k]];
            pregb[k] = group_map[src_b[k]];
            pdest[k] = (issue[k] && dst[k] == ZERO_REG) ? group_map[ZERO_REG] : alloc_idx[k];
            if (alloc_need[k]) group_map[dst[k]] = alloc_idx[k];
            if (issue[k] && ckpt_req[k]) begin
                snap_rat = group_map;
                snap_fl  = avail[k+1];
            end
        end
    end

    // Retires applied oldest first, so a same-dest younger way frees the older way's preg.
    always_comb begin
        rrat_next   = rrat_reg;
        retire_free = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (retire[k] && rdst[k] != ZERO_REG) begin
                retire_free[rrat_next[rdst[k]]] = 1'b1;
                rrat_next[rdst[k]] = rpd[k];
            end
        end
        rrat_used = '0;
        for (int i = 0; i < ARCH_REGS; i++) begin
            rrat_used[rrat_next[i]] = 1'b1;
        end
        flush_fl = ~rrat_used;
    end

    // Slots strictly younger than recover_id, up to the old tail, are squashed.
    always_comb begin
        squash_span = tail_reg - recover_id - CKPT_IDX'(1);
        for (int i = 0; i < CKPTS; i++) begin
            squash_mask[i] = (CKPT_IDX'(i) - recover_id - CKPT_IDX'(1)) < squash_span;
        end
        ckpt_valid_next = ckpt_valid_reg;
        if (release_en && !(recover && recover_id == release_id)) begin
            ckpt_valid_next[release_id] = 1'b0;
        end
        if (flush) begin
            ckpt_valid_next = '0;
        end else if (recover) begin
            ckpt_valid_next = ckpt_valid_next & ~squash_mask;
        end else if (accept && any_ckpt) begin
            ckpt_valid_next[tail_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rat_reg        <= identity_map();
            rrat_reg       <= identity_map();
            ckpt_valid_reg <= '0;
            tail_reg       <= '0;
        end else begin
            rrat_reg       <= rrat_next;
            ckpt_valid_reg <= ckpt_valid_next;
            if (flush) begin
                rat_reg  <= rrat_next;
                tail_reg <= '0;
            end else if (recover) begin
                rat_reg  <= ckpt_rat_reg[recover_id];
                tail_reg <= recover_id + CKPT_IDX'(1);
            end else if (accept) begin
                rat_reg <= group_map;
                if (any_ckpt) tail_reg <= tail_reg + CKPT_IDX'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CKPTS; i++) begin
            if (ckpt_valid_reg[i]) ckpt_fl_reg[i] <= ckpt_fl_reg[i] | retire_free;
        end
        if (!reset && !flush && !recover && accept && any_ckpt) begin
            ckpt_rat_reg[tail_reg] <= snap_rat;
            ckpt_fl_reg[tail_reg]  <= snap_fl | retire_free;
        end
    end

    assign prega_idx_out = prega;
    assign pregb_idx_out = pregb;
    assign pdest_idx_out = pdest;
    assign ckpt_id_out   = {WAYS{tail_reg}};
    assign stall_out     = stall;
    assign free_cnt_out  = free_cnt;

    a_one_ckpt: assert property (@(posedge clk) disable iff (reset) $onehot0(ckpt_req));
    a_recover_valid: assert property (@(posedge clk) disable iff (reset)
        recover |-> ckpt_valid_reg[recover_id]);
    a_release_valid: assert property (@(posedge clk) disable iff (reset)
        release_en |-> ckpt_valid_reg[release_id]);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_retire_chk
            a_retire_live: assert property (@(posedge clk) disable iff (reset)
                (retire[gi] && rdst[gi] != ZERO_REG) |-> !free_vec[rpd[gi]]);
        end
    endgenerate

endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: sequential rename model checked every cycle plus directed literal checks.
module tb_rat_ckpt;
    import rat_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  issue, ckpt_req, retire;
    logic [9:0]  rega_idx_in, regb_idx_in, dest_idx_in, retire_dest_idx_in;
    logic [11:0] retire_pdest_idx_in, prega_idx_out, pregb_idx_out, pdest_idx_out;
    logic [3:0]  ckpt_id_out;
    logic        stall_out;
    logic [6:0]  free_cnt_out;
    logic        recover, release_en, flush;
    logic [1:0]  recover_id, release_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rat_ckpt dut (
        .clk                 (clk),
        .reset               (reset),
        .issue               (issue),
        .rega_idx_in         (rega_idx_in),
        .regb_idx_in         (regb_idx_in),
        .dest_idx_in         (dest_idx_in),
        .ckpt_req            (ckpt_req),
        .prega_idx_out       (prega_idx_out),
        .pregb_idx_out       (pregb_idx_out),
        .pdest_idx_out       (pdest_idx_out),
        .ckpt_id_out         (ckpt_id_out),
        .stall_out           (stall_out),
        .free_cnt_out        (free_cnt_out),
        .retire              (retire),
        .retire_dest_idx_in  (retire_dest_idx_in),
        .retire_pdest_idx_in (retire_pdest_idx_in),
        .recover             (recover),
        .recover_id          (recover_id),
        .release_en          (release_en),
        .release_id          (release_id),
        .flush               (flush)
    );

    typedef int map_m[32];
    typedef bit set_m[64];

    map_m m_rat, m_rrat;
    set_m m_free;
    map_m m_crat[4];
    set_m m_cfree[4];
    bit   m_cv[4];
    int   m_tail;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int lowest(set_m s);
        for (int i = 0; i < 64; i++) if (s[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_rrat[i] = i; end
        for (int i = 0; i < 64; i++) m_free[i] = (i >= 32);
        for (int s = 0; s < 4; s++) m_cv[s] = 0;
        m_tail = 0;
    endtask

    // One rename group processed instruction by instruction against a scratch copy of the table.
    task automatic model_step();
        map_m t, snap_r, rr;
        set_m f, snap_f, freed;
        int cnt, pd, d, s;
        bit stall_e, any_ck;
        cnt = 0;
        for (int i = 0; i < 64; i++) if (m_free[i]) cnt++;
        any_ck = ((issue & ckpt_req) != 0);
        stall_e = (cnt < 2) || (any_ck && m_cv[m_tail]);
        chk("free_cnt", int'(free_cnt_out), cnt);
        chk("stall", int'(stall_out), int'(stall_e));
        t = m_rat; f = m_free; snap_r = m_rat; snap_f = m_free;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("prega%0d", w), int'(prega_idx_out[w*6 +: 6]), t[rega_idx_in[w*5 +: 5]]);
            chk($sformatf("pregb%0d", w), int'(pregb_idx_out[w*6 +: 6]), t[regb_idx_in[w*5 +: 5]]);
            d = int'(dest_idx_in[w*5 +: 5]);
            if (issue[w] && d == 31) pd = t[31];
            else pd = lowest(f);
            if (issue[w] && d != 31) begin f[pd] = 0; t[d] = pd; end
            if (!stall_e) chk($sformatf("pdest%0d", w), int'(pdest_idx_out[w*6 +: 6]), pd);
            if (issue[w] && ckpt_req[w]) begin
                snap_r = t; snap_f = f;
                chk($sformatf("ckpt_id%0d", w), int'(ckpt_id_out[w*2 +: 2]), m_tail);
            end
        end
        $display("cycle issue=%b ckpt=%b retire=%b rec=%0b rel=%0b flush=%0b stall=%0b free=%0d",
                 issue, ckpt_req, retire, recover, release_en, flush, stall_out, free_cnt_out);

        rr = m_rrat;
        for (int i = 0; i < 64; i++) freed[i] = 0;
        for (int w = 0; w < 2; w++) begin
            d = int'(retire_dest_idx_in[w*5 +: 5]);
            if (retire[w] && d != 31) begin
                freed[rr[d]] = 1;
                rr[d] = int'(retire_pdest_idx_in[w*6 +: 6]);
            end
        end
        m_rrat = rr;
        if (release_en && !(recover && recover_id == release_id)) m_cv[release_id] = 0;
        for (int c = 0; c < 4; c++)
            if (m_cv[c]) for (int i = 0; i < 64; i++) if (freed[i]) m_cfree[c][i] = 1;
        if (flush) begin
            m_rat = rr;
            for (int i = 0; i < 64; i++) m_free[i] = 1;
            for (int a = 0; a < 32; a++) m_free[rr[a]] = 0;
            for (int c = 0; c < 4; c++) m_cv[c] = 0;
            m_tail = 0;
        end else if (recover) begin
            m_rat = m_crat[recover_id];
            m_free = m_cfree[recover_id];
            for (int i = 0; i < 64; i++) if (freed[i]) m_free[i] = 1;
            s = (int'(recover_id) + 1) % 4;
            while (s != m_tail) begin m_cv[s] = 0; s = (s + 1) % 4; end
            m_tail = (int'(recover_id) + 1) % 4;
        end else if (!stall_e) begin
            m_rat = t;
            m_free = f;
            for (int i = 0; i < 64; i++) if (freed[i]) m_free[i] = 1;
            if (any_ck) begin
                for (int i = 0; i < 64; i++) if (freed[i]) snap_f[i] = 1;
                m_crat[m_tail] = snap_r;
                m_cfree[m_tail] = snap_f;
                m_cv[m_tail] = 1;
                m_tail = (m_tail + 1) % 4;
            end
        end else begin
            for (int i = 0; i < 64; i++) if (freed[i]) m_free[i] = 1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    task automatic clr();
        issue = '0; ckpt_req = '0; retire = '0;
        rega_idx_in = '0; regb_idx_in = '0; dest_idx_in = '0;
        retire_dest_idx_in = '0; retire_pdest_idx_in = '0;
        recover = 0; recover_id = '0; release_en = 0; release_id = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic set_way(int w, int ra, int rb, int d, bit ck);
        issue[w] = 1'b1;
        ckpt_req[w] = ck;
        rega_idx_in[w*5 +: 5] = 5'(ra);
        regb_idx_in[w*5 +: 5] = 5'(rb);
        dest_idx_in[w*5 +: 5] = 5'(d);
    endtask

    task automatic set_retire(int w, int d, int p);
        retire[w] = 1'b1;
        retire_dest_idx_in[w*5 +: 5] = 5'(d);
        retire_pdest_idx_in[w*6 +: 6] = 6'(p);
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_free_cnt", int'(free_cnt_out), 32);
        chk("rst_stall", int'(stall_out), 0);
        chk("rst_pdest0", int'(pdest_idx_out[5:0]), 32);

        // Plain two-way rename
        set_way(0, 15, 14, 4, 0);
        set_way(1, 13, 12, 5, 0);
        #1;
        chk("t1_prega0", int'(prega_idx_out[5:0]), 15);
        chk("t1_prega1", int'(prega_idx_out[11:6]), 13);
        chk("t1_pregb0", int'(pregb_idx_out[5:0]), 14);
        chk("t1_pregb1", int'(pregb_idx_out[11:6]), 12);
        chk("t1_pdest0", int'(pdest_idx_out[5:0]), 32);
        chk("t1_pdest1", int'(pdest_idx_out[11:6]), 33);
        tick();
        clr();
        rega_idx_in[4:0] = 5'd4;
        regb_idx_in[4:0] = 5'd5;
        #1;
        chk("t1_rat4", int'(prega_idx_out[5:0]), 32);
        chk("t1_rat5", int'(pregb_idx_out[5:0]), 33);
        chk("t1_free_cnt", int'(free_cnt_out), 30);
        tick();

        // Intra-group dependency and same-dest writers
        do_reset();
        set_way(0, 0, 0, 3, 0);
        set_way(1, 3, 0, 3, 0);
        #1;
        chk("t2_prega1", int'(prega_idx_out[11:6]), 32);
        chk("t2_pdest0", int'(pdest_idx_out[5:0]), 32);
        chk("t2_pdest1", int'(pdest_idx_out[11:6]), 33);
        tick();
        clr();
        rega_idx_in[4:0] = 5'd3;
        #1;
        chk("t2_rat3", int'(prega_idx_out[5:0]), 33);
        tick();

        // Checkpoint then mispredict recovery
        do_reset();
        set_way(0, 0, 0, 7, 1);
        #1;
        chk("t3_pdest0", int'(pdest_idx_out[5:0]), 32);
        chk("t3_ckpt_id", int'(ckpt_id_out[1:0]), 0);
        tick();
        clr();
        set_way(0, 0, 0, 7, 0);
        #1;
        chk("t3_pdest_wrong", int'(pdest_idx_out[5:0]), 33);
        tick();
        clr();
        recover = 1;
        recover_id = 2'd0;
        tick();
        clr();
        rega_idx_in[4:0] = 5'd7;
        set_way(1, 0, 0, 8, 1);
        issue[0] = 1'b0;
        #1;
        chk("t3_rat7", int'(prega_idx_out[5:0]), 32);
        chk("t3_free_cnt", int'(free_cnt_out), 31);
        chk("t3_ckpt_id1", int'(ckpt_id_out[3:2]), 1);
        chk("t3_pdest1", int'(pdest_idx_out[11:6]), 33);
        tick();

        // Exhaust the free list, then drain via retire
        do_reset();
        for (int c = 0; c < 16; c++) begin
            set_way(0, 0, 0, 1, 0);
            set_way(1, 0, 0, 2, 0);
            tick();
        end
        rega_idx_in[4:0] = 5'd1;
        #1;
        chk("t4_free_cnt0", int'(free_cnt_out), 0);
        chk("t4_stall", int'(stall_out), 1);
        chk("t4_rat1", int'(prega_idx_out[5:0]), 62);
        tick();
        set_retire(0, 1, 32);
        tick();
        retire = '0;
        #1;
        chk("t4_free_cnt1", int'(free_cnt_out), 1);
        chk("t4_stall1", int'(stall_out), 1);
        set_retire(0, 2, 33);
        tick();
        retire = '0;
        #1;
        chk("t4_free_cnt2", int'(free_cnt_out), 2);
        chk("t4_stall2", int'(stall_out), 0);
        chk("t4_pdest0", int'(pdest_idx_out[5:0]), 1);
        chk("t4_pdest1", int'(pdest_idx_out[11:6]), 2);
        tick();

        // Retire and flush in the same cycle
        do_reset();
        set_way(0, 0, 0, 4, 1);
        tick();
        clr();
        set_retire(0, 4, 32);
        flush = 1;
        tick();
        clr();
        rega_idx_in[4:0] = 5'd4;
        set_way(0, 4, 0, 9, 1);
        #1;
        chk("t5_rat4", int'(prega_idx_out[5:0]), 32);
        chk("t5_free_cnt", int'(free_cnt_out), 32);
        chk("t5_pdest0", int'(pdest_idx_out[5:0]), 4);
        chk("t5_ckpt_id", int'(ckpt_id_out[1:0]), 0);
        chk("t5_stall", int'(stall_out), 0);
        tick();

        // Checkpoint slots full, release, zero-register destination
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_way(0, 0, 0, 10, 1);
            #1;
            chk($sformatf("t6_ckpt_id_%0d", c), int'(ckpt_id_out[1:0]), c);
            tick();
        end
        #1;
        chk("t6_stall_full", int'(stall_out), 1);
        tick();
        release_en = 1;
        release_id = 2'd0;
        #1;
        chk("t6_stall_rel", int'(stall_out), 1);
        tick();
        release_en = 0;
        #1;
        chk("t6_stall_clear", int'(stall_out), 0);
        chk("t6_ckpt_reuse", int'(ckpt_id_out[1:0]), 0);
        tick();
        clr();
        set_way(0, 0, 0, 31, 0);
        #1;
        chk("t6_pdest_zero", int'(pdest_idx_out[5:0]), 31);
        chk("t6_free_before", int'(free_cnt_out), 27);
        tick();
        clr();
        #1;
        chk("t6_free_after", int'(free_cnt_out), 27);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
